// File: rtl/soc_cmd_receiver_pkg.sv
// soc_cmd_pkg: export-word field positions, opcodes and receiver state.
// Shared by the command receiver, its FIFO and its handshake interface.
package soc_cmd_pkg;

   localparam int SEQ_MSB = 31;
   localparam int SEQ_LSB = 28;
   localparam int OP_MSB  = 27;
   localparam int OP_LSB  = 24;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_KEY   = 4'd1;
   localparam logic [3:0] OP_SPAWN = 4'd2;
   localparam logic [3:0] OP_LEVEL = 4'd3;
   localparam logic [3:0] OP_PAUSE = 4'd4;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

endpackage

// File: rtl/soc_cmd_receiver_if.sv
// soc_cmd_receiver_if: queued-command valid/ready handshake.
// master = receiver (drives valid/opcode/payload), slave = game logic (drives ready).
interface soc_cmd_receiver_if #(
   parameter int PAYLOAD_W = 24
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [3:0]           cmd_opcode;
   logic [PAYLOAD_W-1:0] cmd_payload;

   modport master (
      output cmd_valid,
      output cmd_opcode,
      output cmd_payload,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_opcode,
      input  cmd_payload,
      output cmd_ready
   );
endinterface

// File: rtl/soc_cmd_receiver_fifo.sv
// soc_cmd_fifo: first-word-fall-through synchronous FIFO.
// Ports: Clk, Reset (sync, high), push/din, pop, dout (head), full, empty, level.
module soc_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 28,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [W-1:0]  r_last;

   logic          w_pop;
   logic          w_push;

   assign full  = (r_level == LW'(DEPTH));
   assign empty = (r_level == '0);
   assign level = r_level;

   // A pop frees a slot in the same edge, so push is accepted when full
   // as long as a pop happens alongside it.
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   // When empty the head shows the last popped entry instead of stale RAM.
   assign dout = empty ? r_last : r_mem[r_rd_ptr];

   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_last   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_last   <= r_mem[r_rd_ptr];
         end
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/soc_cmd_receiver.sv
// soc_cmd_receiver: decodes tagged SoC export words into key updates and queued commands.
// Ports: Clk, Reset, export_word, cmd_if (master), key_state, fifo_level, overflow_count.
module soc_cmd_receiver
   import soc_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int PAYLOAD_W  = 24
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [31:0]        export_word,
   soc_cmd_receiver_if.master cmd_if,
   output logic [7:0]         key_state,
   output logic [4:0]         fifo_level,
   output logic [7:0]         overflow_count
);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int DW = 4 + PAYLOAD_W;

   logic [31:0]          r_word_q;
   logic [3:0]           r_last_seq;
   state_t               r_state;
   logic [7:0]           r_key_state;
   logic [7:0]           r_ovf;

   state_t               w_state_nxt;
   logic                 w_seq_load;
   logic                 w_push;
   logic                 w_key_we;
   logic [3:0]           w_seq;
   logic [3:0]           w_op;
   logic [PAYLOAD_W-1:0] w_payload;
   logic [DW-1:0]        w_dout;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_drop;
   logic [LW-1:0]        w_level;

   // Sampled even during reset, so INIT sees the word present at reset
   // and absorbs its tag instead of replaying it.
   always_ff @(posedge Clk) begin
      r_word_q <= export_word;
   end

   assign w_seq     = r_word_q[SEQ_MSB:SEQ_LSB];
   assign w_op      = r_word_q[OP_MSB:OP_LSB];
   assign w_payload = r_word_q[PAYLOAD_W-1:0];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_seq_load  = 1'b0;
      w_push      = 1'b0;
      w_key_we    = 1'b0;
      unique case (r_state)
         INIT: begin
            w_seq_load  = 1'b1;
            w_state_nxt = RUN;
         end
         RUN: begin
            if (w_seq != r_last_seq) begin
               w_seq_load = 1'b1;
               if (w_op == OP_KEY) begin
                  w_key_we = 1'b1;
               end else if (w_op != OP_NOP) begin
                  w_push = 1'b1;
               end
            end
         end
         default: w_state_nxt = INIT;
      endcase
   end

   assign w_pop  = ~w_empty & cmd_if.cmd_ready;
   assign w_drop = w_push & w_full & ~w_pop;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_last_seq  <= '0;
         r_key_state <= '0;
         r_ovf       <= '0;
      end else begin
         if (w_seq_load) begin
            r_last_seq <= w_seq;
         end
         if (w_key_we) begin
            r_key_state[w_payload[2:0]] <= w_payload[8];
         end
         if (w_drop && (r_ovf != 8'hFF)) begin
            r_ovf <= r_ovf + 8'd1;
         end
      end
   end

   soc_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DW),
      .LW    (LW)
   ) u_fifo (
      .Clk   (Clk),
      .Reset (Reset),
      .push  (w_push),
      .din   ({w_op, w_payload}),
      .pop   (w_pop),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .level (w_level)
   );

   assign cmd_if.cmd_valid   = ~w_empty;
   assign cmd_if.cmd_opcode  = w_dout[DW-1 -: 4];
   assign cmd_if.cmd_payload = w_dout[PAYLOAD_W-1:0];

   assign key_state      = r_key_state;
   assign fifo_level     = 5'(w_level);
   assign overflow_count = r_ovf;

endmodule

// File: tb/tb_soc_cmd_receiver.sv
// tb_soc_cmd_receiver: directed checks of tag detection, key updates and FIFO.
// Drives on the falling edge, samples on the falling edge after each rising edge.
module tb_soc_cmd_receiver;
   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] export_word;
   logic [7:0]  key_state;
   logic [4:0]  fifo_level;
   logic [7:0]  overflow_count;

   int n_tests = 0;
   int n_fail  = 0;

   soc_cmd_receiver_if #(.PAYLOAD_W(24)) u_if ();

   soc_cmd_receiver #(
      .FIFO_DEPTH (4),
      .PAYLOAD_W  (24)
   ) u_dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .export_word    (export_word),
      .cmd_if         (u_if.master),
      .key_state      (key_state),
      .fifo_level     (fifo_level),
      .overflow_count (overflow_count)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      Reset          = 1'b1;
      export_word    = 32'h5200_0001;
      u_if.cmd_ready = 1'b0;
      repeat (2) tick();
      chk("rst_valid", 32'(u_if.cmd_valid), 32'd0);
      chk("rst_op", 32'(u_if.cmd_opcode), 32'd0);
      chk("rst_pl", 32'(u_if.cmd_payload), 32'd0);
      chk("rst_key", 32'(key_state), 32'd0);
      chk("rst_lvl", 32'(fifo_level), 32'd0);
      chk("rst_ovf", 32'(overflow_count), 32'd0);

      Reset = 1'b0;
      repeat (10) tick();
      chk("stale_valid", 32'(u_if.cmd_valid), 32'd0);
      chk("stale_lvl", 32'(fifo_level), 32'd0);

      export_word = 32'h6200_00AB;
      tick();
      chk("lat1_valid", 32'(u_if.cmd_valid), 32'd0);
      tick();
      chk("lat2_valid", 32'(u_if.cmd_valid), 32'd1);
      chk("lat2_op", 32'(u_if.cmd_opcode), 32'd2);
      chk("lat2_pl", 32'(u_if.cmd_payload), 32'h0000AB);
      chk("lat2_lvl", 32'(fifo_level), 32'd1);

      export_word = 32'h7100_0103;
      repeat (2) tick();
      chk("key_set", 32'(key_state), 32'h08);
      export_word = 32'h8100_0003;
      repeat (2) tick();
      chk("key_clr", 32'(key_state), 32'h00);
      chk("key_lvl", 32'(fifo_level), 32'd1);

      u_if.cmd_ready = 1'b1;
      tick();
      u_if.cmd_ready = 1'b0;
      chk("pop1_lvl", 32'(fifo_level), 32'd0);
      chk("pop1_valid", 32'(u_if.cmd_valid), 32'd0);
      tick();
      chk("empty_rdy_op", 32'(u_if.cmd_opcode), 32'd2);
      chk("empty_rdy_pl", 32'(u_if.cmd_payload), 32'h0000AB);

      for (int i = 1; i <= 6; i++) begin
         export_word = {4'(i), 4'd3, 24'h000100 + 24'(i)};
         tick();
      end
      repeat (2) tick();
      chk("ovf_lvl", 32'(fifo_level), 32'd4);
      chk("ovf_cnt", 32'(overflow_count), 32'd2);

      u_if.cmd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", 32'(u_if.cmd_valid), 32'd1);
         chk("drain_op", 32'(u_if.cmd_opcode), 32'd3);
         chk("drain_pl", 32'(u_if.cmd_payload), 32'h000100 + 32'(i));
         tick();
      end
      u_if.cmd_ready = 1'b0;
      chk("drain_lvl", 32'(fifo_level), 32'd0);
      chk("drain_hold_pl", 32'(u_if.cmd_payload), 32'h000104);

      for (int i = 7; i <= 10; i++) begin
         export_word = {4'(i), 4'd4, 24'h000200 + 24'(i - 6)};
         tick();
      end
      repeat (2) tick();
      chk("refill_lvl", 32'(fifo_level), 32'd4);

      export_word = 32'hB300_0205;
      tick();
      u_if.cmd_ready = 1'b1;
      tick();
      u_if.cmd_ready = 1'b0;
      chk("pp_lvl", 32'(fifo_level), 32'd4);
      chk("pp_ovf", 32'(overflow_count), 32'd2);
      chk("pp_head", 32'(u_if.cmd_payload), 32'h000202);

      export_word = 32'hB300_02FF;
      repeat (3) tick();
      chk("same_tag_lvl", 32'(fifo_level), 32'd4);
      chk("same_tag_ovf", 32'(overflow_count), 32'd2);

      u_if.cmd_ready = 1'b1;
      tick();
      u_if.cmd_ready = 1'b0;
      chk("pop3_lvl", 32'(fifo_level), 32'd3);
      chk("pop3_head", 32'(u_if.cmd_payload), 32'h000203);

      export_word = 32'hC100_0105;
      repeat (2) tick();
      chk("key5", 32'(key_state), 32'h20);
      chk("key5_lvl", 32'(fifo_level), 32'd3);

      Reset = 1'b1;
      tick();
      chk("mid_rst_lvl", 32'(fifo_level), 32'd0);
      chk("mid_rst_valid", 32'(u_if.cmd_valid), 32'd0);
      chk("mid_rst_key", 32'(key_state), 32'd0);
      chk("mid_rst_ovf", 32'(overflow_count), 32'd0);
      Reset = 1'b0;
      repeat (3) tick();
      chk("post_rst_valid", 32'(u_if.cmd_valid), 32'd0);
      chk("post_rst_key", 32'(key_state), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
